// File: rtl/best_neighbor_scan.sv
// Scans a neighbour table in memory for the lowest-value entry and records the
// index of every entry whose value beats our own current best.
//
// state      | meaning
// IDLE       | waiting for start; results held
// RD_COUNT   | address of neighbour-count word driven
// CAP_COUNT  | count captured and clamped
// RD_ID      | address of entry ID driven
// CAP_ID     | entry ID captured
// RD_VAL     | address of entry value driven
// CAP_VAL    | entry value captured
// RD_HOP     | address of entry hop driven
// CAP_HOP    | hop captured, entry compared against best and mybest
// WR_BETTER  | one-cycle write of entry index into the better list
// FINISH     | scan complete, done raised on exit
module best_neighbor_scan #(
  parameter logic [15:0] NEIGHBOR_BASE = 16'h0100,
  parameter logic [15:0] BETTER_BASE   = 16'h0200,
  parameter int          MAX_NEIGHBORS = 16
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] mybest,
  output logic [15:0] address,
  output logic        wr_en,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic [15:0] bestvalue,
  output logic [15:0] besthop,
  output logic [15:0] bestneighborID,
  output logic [15:0] betterNeighborCount,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] MAX_N = 16'(MAX_NEIGHBORS);

  typedef enum logic [3:0] {
    IDLE,
    RD_COUNT,
    CAP_COUNT,
    RD_ID,
    CAP_ID,
    RD_VAL,
    CAP_VAL,
    RD_HOP,
    CAP_HOP,
    WR_BETTER,
    FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mybest_q, mybest_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] id_q, id_d;
  logic [15:0] val_q, val_d;
  logic [15:0] address_q, address_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] bestvalue_q, bestvalue_d;
  logic [15:0] besthop_q, besthop_d;
  logic [15:0] bestid_q, bestid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] count_clamped;
  logic        last_entry;

  assign count_clamped = (mem_data_out > MAX_N) ? MAX_N : mem_data_out;
  assign last_entry    = (idx_q + 16'd1) == n_q;

  always_comb begin
    state_d     = state_q;
    mybest_d    = mybest_q;
    n_d         = n_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    val_d       = val_q;
    address_d   = address_q;
    wr_en_d     = 1'b0;
    wdata_d     = wdata_q;
    bestvalue_d = bestvalue_q;
    besthop_d   = besthop_q;
    bestid_d    = bestid_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RD_COUNT;
          mybest_d    = mybest;
          address_d   = NEIGHBOR_BASE;
          ptr_d       = NEIGHBOR_BASE + 16'd1;
          idx_d       = 16'd0;
          bestvalue_d = 16'hFFFF;
          besthop_d   = 16'd0;
          bestid_d    = 16'hFFFF;
          cnt_d       = 16'd0;
          busy_d      = 1'b1;
        end
      end
      RD_COUNT: state_d = CAP_COUNT;
      CAP_COUNT: begin
        n_d = count_clamped;
        if (count_clamped == 16'd0) begin
          state_d = FINISH;
        end else begin
          state_d   = RD_ID;
          address_d = ptr_q;
          ptr_d     = ptr_q + 16'd1;
        end
      end
      RD_ID: state_d = CAP_ID;
      CAP_ID: begin
        id_d      = mem_data_out;
        state_d   = RD_VAL;
        address_d = ptr_q;
        ptr_d     = ptr_q + 16'd1;
      end
      RD_VAL: state_d = CAP_VAL;
      CAP_VAL: begin
        val_d     = mem_data_out;
        state_d   = RD_HOP;
        address_d = ptr_q;
        ptr_d     = ptr_q + 16'd1;
      end
      RD_HOP: state_d = CAP_HOP;
      CAP_HOP: begin
        // strict compare: on a tie the earlier entry stays best
        if (val_q < bestvalue_q) begin
          bestvalue_d = val_q;
          besthop_d   = mem_data_out;
          bestid_d    = id_q;
        end
        if (val_q < mybest_q) begin
          state_d   = WR_BETTER;
          address_d = BETTER_BASE + cnt_q;
          wdata_d   = idx_q;
          wr_en_d   = 1'b1;
        end else begin
          idx_d = idx_q + 16'd1;
          if (last_entry) begin
            state_d = FINISH;
          end else begin
            state_d   = RD_ID;
            address_d = ptr_q;
            ptr_d     = ptr_q + 16'd1;
          end
        end
      end
      WR_BETTER: begin
        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q + 16'd1;
        if (last_entry) begin
          state_d = FINISH;
        end else begin
          state_d   = RD_ID;
          address_d = ptr_q;
          ptr_d     = ptr_q + 16'd1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q     <= IDLE;
      mybest_q    <= 16'd0;
      n_q         <= 16'd0;
      idx_q       <= 16'd0;
      ptr_q       <= 16'd0;
      id_q        <= 16'd0;
      val_q       <= 16'd0;
      address_q   <= 16'd0;
      wr_en_q     <= 1'b0;
      wdata_q     <= 16'd0;
      bestvalue_q <= 16'hFFFF;
      besthop_q   <= 16'd0;
      bestid_q    <= 16'hFFFF;
      cnt_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mybest_q    <= mybest_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      val_q       <= val_d;
      address_q   <= address_d;
      wr_en_q     <= wr_en_d;
      wdata_q     <= wdata_d;
      bestvalue_q <= bestvalue_d;
      besthop_q   <= besthop_d;
      bestid_q    <= bestid_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign address             = address_q;
  assign wr_en               = wr_en_q;
  assign mem_data_in         = wdata_q;
  assign bestvalue           = bestvalue_q;
  assign besthop             = besthop_q;
  assign bestneighborID      = bestid_q;
  assign betterNeighborCount = cnt_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_best_neighbor_scan.sv
// Scoreboard bench for best_neighbor_scan: a memory model answers reads, a
// monitor checks every write and every done pulse against queued expectations.
module tb_best_neighbor_scan;

  localparam logic [15:0] NB = 16'h0100;
  localparam logic [15:0] BB = 16'h0200;

  logic        clock;
  logic        nrst;
  logic        start;
  logic [15:0] mybest;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic [15:0] bestvalue;
  logic [15:0] besthop;
  logic [15:0] bestneighborID;
  logic [15:0] betterNeighborCount;
  logic        busy;
  logic        done;

  best_neighbor_scan dut (
    .clock(clock),
    .nrst(nrst),
    .start(start),
    .mybest(mybest),
    .address(address),
    .wr_en(wr_en),
    .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .bestvalue(bestvalue),
    .besthop(besthop),
    .bestneighborID(bestneighborID),
    .betterNeighborCount(betterNeighborCount),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [15:0] bv;
    logic [15:0] bh;
    logic [15:0] bid;
    logic [15:0] cnt;
    int          done_cyc;
  } res_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  res_t rq[$];
  wr_t  wq[$];

  logic [15:0] mem [0:65535];
  int cyc;
  int total;
  int bad;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    mem_data_out <= mem[address];
    if (wr_en) mem[address] <= mem_data_in;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT writes or signals done
  always @(negedge clock) begin
    if (nrst) begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %h data %h", address, mem_data_in);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", address, w.addr);
          chk("wr_data", mem_data_in, w.data);
        end
      end
      if (done) begin
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: at cycle %0d", cyc);
        end else begin
          res_t r;
          r = rq.pop_front();
          chk("bestvalue", bestvalue, r.bv);
          chk("besthop", besthop, r.bh);
          chk("bestneighborID", bestneighborID, r.bid);
          chk("betterNeighborCount", betterNeighborCount, r.cnt);
          chk_int("done_cycle", cyc, r.done_cyc);
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 80; i++) begin
      mem[NB + 16'(i)] = 16'h0;
      mem[BB + 16'(i)] = 16'h0;
    end
  endtask

  task automatic put_entry(input int i, input logic [15:0] id, input logic [15:0] val,
                           input logic [15:0] hop);
    mem[NB + 16'd1 + 16'(3 * i)]     = id;
    mem[NB + 16'd1 + 16'(3 * i + 1)] = val;
    mem[NB + 16'd1 + 16'(3 * i + 2)] = hop;
  endtask

  task automatic start_scan(input logic [15:0] mb, output int k);
    @(negedge clock);
    mybest = mb;
    start  = 1'b1;
    k      = cyc + 1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic push_res(input logic [15:0] bv, input logic [15:0] bh, input logic [15:0] bid,
                          input logic [15:0] cnt, input int dc);
    res_t r;
    r.bv = bv; r.bh = bh; r.bid = bid; r.cnt = cnt; r.done_cyc = dc;
    rq.push_back(r);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: results left %0d writes left %0d", name, rq.size(), wq.size());
      rq.delete();
      wq.delete();
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bestvalue"}, bestvalue, 16'hFFFF);
    chk({tag, "_bestID"}, bestneighborID, 16'hFFFF);
    chk({tag, "_besthop"}, besthop, 16'h0);
    chk({tag, "_count"}, betterNeighborCount, 16'h0);
    chk({tag, "_address"}, address, 16'h0);
    chk({tag, "_mem_data_in"}, mem_data_in, 16'h0);
    chk({tag, "_wr_en"}, {15'd0, wr_en}, 16'h0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'h0);
    chk({tag, "_done"}, {15'd0, done}, 16'h0);
  endtask

  task automatic load_three();
    clear_mem();
    mem[NB] = 16'd3;
    put_entry(0, 16'd4, 16'd8, 16'd50);
    put_entry(1, 16'd7, 16'd3, 16'd20);
    put_entry(2, 16'd9, 16'd6, 16'd40);
  endtask

  initial begin
    int k;
    cyc    = 0;
    total  = 0;
    bad    = 0;
    nrst   = 1'b0;
    start  = 1'b0;
    mybest = 16'h0;
    clear_mem();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    nrst = 1'b1;

    // empty table
    mem[NB] = 16'd0;
    start_scan(16'd5, k);
    push_res(16'hFFFF, 16'h0, 16'hFFFF, 16'h0, k + 3);
    drain("empty");

    // three entries, two beat mybest
    load_three();
    start_scan(16'd7, k);
    push_wr(BB, 16'd1);
    push_wr(BB + 16'd1, 16'd2);
    push_res(16'd3, 16'd20, 16'd7, 16'd2, k + 3 + 18 + 2);
    drain("three");
    chk("mem_0200", mem[BB], 16'd1);
    chk("mem_0201", mem[BB + 16'd1], 16'd2);
    chk("held_bestvalue", bestvalue, 16'd3);
    chk("held_bestID", bestneighborID, 16'd7);

    // tie keeps the earlier entry
    clear_mem();
    mem[NB] = 16'd2;
    put_entry(0, 16'd2, 16'd5, 16'd10);
    put_entry(1, 16'd3, 16'd5, 16'd11);
    start_scan(16'd1, k);
    push_res(16'd5, 16'd10, 16'd2, 16'd0, k + 3 + 12);
    drain("tie");

    // count above the maximum is clamped to 16 entries
    clear_mem();
    mem[NB] = 16'd20;
    for (int i = 0; i < 20; i++)
      put_entry(i, 16'(100 + i), (i < 16) ? 16'(200 - i) : 16'd1, 16'(i));
    start_scan(16'd190, k);
    for (int j = 0; j < 5; j++) push_wr(BB + 16'(j), 16'(11 + j));
    push_res(16'd185, 16'd15, 16'd115, 16'd5, k + 3 + 96 + 5);
    drain("clamp");

    // reset during the second entry, then a clean rerun
    load_three();
    start_scan(16'd7, k);
    repeat (9) @(negedge clock);
    nrst = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    nrst = 1'b1;
    repeat (3) @(negedge clock);
    chk("after_reset_done", {15'd0, done}, 16'h0);
    start_scan(16'd7, k);
    push_wr(BB, 16'd1);
    push_wr(BB + 16'd1, 16'd2);
    push_res(16'd3, 16'd20, 16'd7, 16'd2, k + 3 + 18 + 2);
    drain("rerun");

    // start pulses while busy must be ignored
    load_three();
    start_scan(16'd7, k);
    push_wr(BB, 16'd1);
    push_wr(BB + 16'd1, 16'd2);
    push_res(16'd3, 16'd20, 16'd7, 16'd2, k + 3 + 18 + 2);
    repeat (3) @(negedge clock);
    chk("busy_mid_scan", {15'd0, busy}, 16'h1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    start = 1'b1;
    mybest = 16'hFFFF;
    @(negedge clock);
    start = 1'b0;
    drain("busy_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/best_neighbor_scan.md
BEST_NEIGHBOR_SCAN -- requirements
Module: best_neighbor_scan

Interface
REQ-001 Parameter NEIGHBOR_BASE, default 16'h0100, SHALL be the address of the neighbour-count word; entries follow from NEIGHBOR_BASE+1.
REQ-002 Parameter BETTER_BASE, default 16'h0200, SHALL be the first address of the better-neighbour index list written by the block.
REQ-003 Parameter MAX_NEIGHBORS, default 16, SHALL be the maximum number of entries scanned.
REQ-004 Ports SHALL be, in order:
- clock  in  1  single clock; all logic is rising-edge.
- nrst  in  1  synchronous, active-low reset.
- start  in  1  scan request, sampled only in IDLE.
- mybest  in  16  own current value, latched at start.
- address  out  16  memory address.
- wr_en  out  1  memory write enable.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  memory read data, valid the cycle after address.
- bestvalue  out  16  minimum neighbour value.
- besthop  out  16  hop field of the best entry.
- bestneighborID  out  16  ID field of the best entry.
- betterNeighborCount  out  16  number of entries with value < mybest.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Function
REQ-005 Each entry i (0-based) SHALL occupy three words at NEIGHBOR_BASE+1+3i: ID, value, hop.
REQ-006 Memory reads SHALL take two cycles (address issue, data capture); mem_data_out SHALL be sampled on the cycle after the address is driven.
REQ-007 States SHALL be: IDLE, RD_COUNT, CAP_COUNT, RD_ID, CAP_ID, RD_VAL, CAP_VAL, RD_HOP, CAP_HOP, WR_BETTER, FINISH.
REQ-008 IDLE->RD_COUNT on start=1; mybest latched; all result registers cleared to reset values.
REQ-009 Captured count N SHALL be clamped to MAX_NEIGHBORS; N=0 SHALL go CAP_COUNT->FINISH.
REQ-010 After CAP_HOP, the entry SHALL be compared unsigned: value < current bestvalue replaces bestvalue/besthop/bestneighborID; ties keep the earlier entry.
REQ-011 If value < mybest (strict, unsigned), the next state SHALL be WR_BETTER: address = BETTER_BASE + betterNeighborCount, mem_data_in = i, wr_en = 1 for exactly one cycle, then count increments.
REQ-012 After the last entry, the block SHALL enter FINISH; done = 1 for one cycle there, then IDLE.
REQ-013 Latency: if start is sampled at edge k, done SHALL be high in the cycle after edge k+3+6N+B (B = better entries).
REQ-014 wr_en SHALL be 0 in every state except WR_BETTER; the block SHALL never write the neighbour table.
REQ-015 start while busy SHALL be ignored; start held high in FINISH SHALL not retrigger until IDLE.
REQ-016 Result outputs SHALL hold their values after done until the next accepted start.
REQ-017 Entry index and address arithmetic SHALL be 16-bit and wrap modulo 2^16 without error.

Reset
REQ-018 nrst=0 at a rising edge SHALL force IDLE, regardless of the current state, including mid-scan.
REQ-019 Reset values SHALL be: bestvalue=16'hFFFF, bestneighborID=16'hFFFF, besthop=0, betterNeighborCount=0, address=0, mem_data_in=0, wr_en=0, busy=0, done=0.
REQ-020 Reset asserted during WR_BETTER SHALL deassert wr_en on the same edge; any partially written list is not cleaned up.

Verification
REQ-021 count=0, mybest=5, start -> done 3 cycles later; bestvalue=FFFF, ID=FFFF, hop=0, count=0; no writes.
REQ-022 3 entries {(4,8,50),(7,3,20),(9,6,40)}, mybest=7 -> best ID=7, value=3, hop=20; betterNeighborCount=2; mem[0200]=1, mem[0201]=2; done at k+3+18+2.
REQ-023 Tie: entries {(2,5,10),(3,5,11)}, mybest=1 -> ID=2, hop=10, count=0, no wr_en pulses.
REQ-024 count=20 -> exactly 16 entries scanned; done at k+3+96+B.
REQ-025 nrst low during the 2nd entry of REQ-022 -> IDLE, all outputs at reset values, wr_en=0; a fresh start then reproduces the REQ-022 results.
REQ-026 start pulsed while busy -> no effect on results or timing; done fires exactly once.
